// File: rtl/fp_posit_pkg.sv
// Shared types and constants for the FP16 x posit MAC array.
package fp_posit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_MUL   = 2'd2,
        ST_ACC   = 2'd3
    } state_t;

    localparam int FP_EXP_W   = 5;
    localparam int FP_MAN_W   = 10;
    localparam int FP_SIG_W   = 11;
    localparam int FP_BIAS    = 15;
    localparam int FP_EXP_MAX = 31;
    // The accumulator LSB carries weight 2^(exp_min - LSB_OFFSET).
    localparam int LSB_OFFSET = 25;

endpackage

// File: rtl/fp_posit_mac_array_decode.sv
// Combinational es=0 posit decoder: right-aligned word of 'precision' bits
// into sign, regime k, significand 1.f (PREC_MAX-3 fraction bits), zero and NaR.
module posit_decode
    import fp_posit_pkg::*;
#(
    parameter int PREC_MAX = 8
) (
    input  logic [PREC_MAX-1:0] bits,
    input  logic [3:0]          precision,
    output logic                sign,
    output logic [4:0]          k,
    output logic [PREC_MAX-3:0] sig,
    output logic                zero,
    output logic                nar
);

    logic [PREC_MAX-1:0] mask;
    logic [PREC_MAX-1:0] top;
    logic [PREC_MAX-1:0] val;
    logic [PREC_MAX-1:0] mag;
    logic [PREC_MAX-1:0] body;
    logic [PREC_MAX-1:0] tmp;
    logic [3:0]          run;
    logic                r0;
    logic                stop;

    always_comb begin
        mask = '0;
        top  = '0;
        for (int i = 0; i < PREC_MAX; i++) begin
            mask[i] = (i < int'(precision));
            top[i]  = (i == int'(precision) - 1);
        end
        val  = bits & mask;
        zero = (val == '0);
        nar  = (val == top);
        sign = |(val & top);
        mag  = sign ? ((~val + 1'b1) & mask) : val;
        // Left-align so the regime always starts just below the MSB; the zero
        // padding below the word terminates any regime run correctly.
        body = mag << (4'(PREC_MAX) - precision);
        r0   = body[PREC_MAX-2];
        run  = '0;
        stop = 1'b0;
        for (int i = PREC_MAX - 2; i >= 0; i--) begin
            if (!stop) begin
                if (body[i] == r0) run = run + 4'd1;
                else               stop = 1'b1;
            end
        end
        k   = r0 ? (5'(run) - 5'd1) : (5'd0 - 5'(run));
        tmp = body << (5'(run) + 5'd2);
        sig = {1'b1, (PREC_MAX-3)'(tmp >> 3)};
    end

endmodule

// File: rtl/fp_posit_mac_array.sv
// LANES-wide FP16 activation x serial posit weight MAC with a shared FSM.
// Define FPMAC_SATURATE_EN to clamp accumulator overflow instead of wrapping.
module fp_posit_mac_array
    import fp_posit_pkg::*;
#(
    parameter int LANES     = 4,
    parameter int ACC_WIDTH = 32,
    parameter int PREC_MAX  = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       set,
    input  logic                       clr,
    input  logic [3:0]                 precision,
    input  logic [LANES*16-1:0]        act,
    input  logic [4:0]                 exp_min,
    input  logic                       valid,
    input  logic [LANES-1:0]           w,
    output logic [4:0]                 exp_out,
    output logic [LANES*ACC_WIDTH-1:0] fixed_point_out,
    output logic                       done,
    output logic                       busy,
    output logic [LANES-1:0]           nar,
    output logic                       prec_err
);

    localparam int SIG_W      = PREC_MAX - 2;
    localparam int FRAC_W     = PREC_MAX - 3;
    localparam int PROD_W     = FP_SIG_W + SIG_W;
    localparam int EXT_W      = ACC_WIDTH + PROD_W + 34;
    localparam int SHIFT_BIAS = LSB_OFFSET - FP_BIAS - FP_MAN_W - FRAC_W;

    state_t             state;
    logic [3:0]         bit_cnt;
    logic [3:0]         prec_q;
    logic [LANES*16-1:0] act_q;
    logic [4:0]         exp_q;
    logic               prec_err_q;
    logic               done_q;
    logic               shift_en;

    assign shift_en = (state == ST_SHIFT) && valid && !prec_err_q;

    // Shared control: set wins in every state and restarts word collection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            bit_cnt    <= '0;
            prec_q     <= '0;
            act_q      <= '0;
            exp_q      <= '0;
            prec_err_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (set) begin
                state      <= ST_SHIFT;
                bit_cnt    <= '0;
                prec_q     <= precision;
                act_q      <= act;
                exp_q      <= exp_min;
                prec_err_q <= (precision < 4'd3) || (precision > 4'(PREC_MAX));
            end else begin
                case (state)
                    ST_SHIFT: begin
                        if (shift_en) begin
                            if (bit_cnt + 4'd1 == prec_q) begin
                                bit_cnt <= '0;
                                state   <= ST_MUL;
                            end else begin
                                bit_cnt <= bit_cnt + 4'd1;
                            end
                        end
                    end
                    ST_MUL: state <= ST_ACC;
                    ST_ACC: begin
                        state  <= ST_SHIFT;
                        done_q <= 1'b1;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    assign exp_out  = exp_q;
    assign done     = done_q;
    assign busy     = (state == ST_MUL) || (state == ST_ACC);
    assign prec_err = prec_err_q;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [PREC_MAX-1:0]  sreg;
        logic                 w_sign;
        logic [4:0]           w_k;
        logic [SIG_W-1:0]     w_sig;
        logic                 w_zero;
        logic                 w_nar;
        logic                 a_sign;
        logic [FP_EXP_W-1:0]  a_exp;
        logic [FP_MAN_W-1:0]  a_man;
        logic [PROD_W-1:0]    prod_c;
        logic [PROD_W-1:0]    prod_q;
        logic [7:0]           shamt_c;
        logic [7:0]           shamt_q;
        logic                 neg_q;
        logic                 kill_q;
        logic                 nar_q;
        logic [ACC_WIDTH-1:0] acc_q;
        logic [ACC_WIDTH-1:0] acc_next;
        logic [EXT_W-1:0]     mag;
        logic [EXT_W-1:0]     addend;
        logic [EXT_W-1:0]     sum;

        assign a_sign = act_q[16*i+15];
        assign a_exp  = act_q[16*i+FP_MAN_W +: FP_EXP_W];
        assign a_man  = act_q[16*i +: FP_MAN_W];

        posit_decode #(.PREC_MAX(PREC_MAX)) u_decode (
            .bits      (sreg),
            .precision (prec_q),
            .sign      (w_sign),
            .k         (w_k),
            .sig       (w_sig),
            .zero      (w_zero),
            .nar       (w_nar)
        );

        assign prod_c  = PROD_W'({1'b1, a_man}) * PROD_W'(w_sig);
        // Two's-complement shift count; negative means shift right.
        assign shamt_c = 8'(a_exp) - 8'(exp_q) + {{3{w_k[4]}}, w_k} + 8'(SHIFT_BIAS);

        always_comb begin
            mag    = shamt_q[7] ? (EXT_W'(prod_q) >> (8'd0 - shamt_q))
                                : (EXT_W'(prod_q) << shamt_q);
            addend = neg_q ? (EXT_W'(0) - mag) : mag;
            sum    = {{(EXT_W-ACC_WIDTH){acc_q[ACC_WIDTH-1]}}, acc_q} + addend;
`ifdef FPMAC_SATURATE_EN
            acc_next = sum[ACC_WIDTH-1:0];
            if ((sum[EXT_W-1:ACC_WIDTH-1] != '0) && (sum[EXT_W-1:ACC_WIDTH-1] != '1))
                acc_next = sum[EXT_W-1] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                        : {1'b0, {(ACC_WIDTH-1){1'b1}}};
`else
            acc_next = ACC_WIDTH'(sum);
`endif
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                sreg    <= '0;
                prod_q  <= '0;
                shamt_q <= '0;
                neg_q   <= 1'b0;
                kill_q  <= 1'b0;
                nar_q   <= 1'b0;
                acc_q   <= '0;
            end else if (set) begin
                sreg <= '0;
                if (clr) acc_q <= '0;
            end else begin
                if (shift_en) sreg <= {sreg[PREC_MAX-2:0], w[i]};
                if (state == ST_MUL) begin
                    prod_q  <= prod_c;
                    shamt_q <= shamt_c;
                    neg_q   <= w_sign ^ a_sign;
                    kill_q  <= w_zero || w_nar || (a_exp == '0) ||
                               (a_exp == FP_EXP_W'(FP_EXP_MAX));
                    nar_q   <= nar_q || w_nar || (a_exp == FP_EXP_W'(FP_EXP_MAX));
                end
                if (state == ST_ACC && !kill_q) acc_q <= acc_next;
            end
        end

        assign fixed_point_out[i*ACC_WIDTH +: ACC_WIDTH] = acc_q;
        assign nar[i] = nar_q;
    end

endmodule

// File: doc/fp_posit_mac_array.md
FP_POSIT_MAC_ARRAY -- requirements
Module: fp_posit_mac_array

Interface
REQ-001 Parameter LANES, default 4: number of independent MAC lanes sharing one control FSM.
REQ-002 Parameter ACC_WIDTH, default 32: signed accumulator width per lane.
REQ-003 Parameter PREC_MAX, default 8: maximum posit weight width in bits; legal precision is 3..PREC_MAX.
REQ-004 Port clk, input, 1: sole clock; all state updates on its rising edge.
REQ-005 Port rst, input, 1: reset, asynchronous and active-high.
REQ-006 Port set, input, 1: one-cycle load strobe for act, exp_min, precision and clr.
REQ-007 Port clr, input, 1: sampled with set; 1 zeroes all accumulators; 0 keeps them.
REQ-008 Port precision, input, 4: posit weight width in bits.
REQ-009 Port act, input, LANES*16: FP16 activations; lane i occupies bits [16i+15:16i].
REQ-010 Port exp_min, input, 5: biased FP16 exponent anchoring the accumulator LSB.
REQ-011 Port valid, input, 1: marks w as carrying one weight bit per lane this cycle.
REQ-012 Port w, input, LANES: serial posit weight bits, MSB first, bit i for lane i.
REQ-013 Port exp_out, output, 5: exp_min latched at the last set.
REQ-014 Port fixed_point_out, output, LANES*ACC_WIDTH: signed accumulators, lane-packed like act.
REQ-015 Port done, output, 1: one-cycle pulse when fixed_point_out reflects a new weight word.
REQ-016 Port busy, output, 1: high in MUL and ACC; valid is ignored while busy.
REQ-017 Port nar, output, LANES: sticky per lane; set when a NaR weight (1 followed by all zeros) is decoded.
REQ-018 Port prec_err, output, 1: high while latched precision is outside 3..PREC_MAX.

Function
REQ-019 FSM states are IDLE, SHIFT, MUL and ACC; set in any state transitions to SHIFT, latches the inputs, clears the bit counter and aborts any word in flight.
REQ-020 In SHIFT, each cycle with valid=1 shifts w into per-lane shift registers; when the count reaches precision the FSM goes to MUL.
REQ-021 MUL decodes each posit (es=0: sign, regime k, fraction) and forms the 11x(PREC_MAX-2)-bit magnitude product; it takes exactly 1 cycle.
REQ-022 ACC shifts the product by (act_exp - exp_min + k) relative to LSB weight 2^(exp_min-25), applies the combined sign, adds it to the accumulator, then returns to SHIFT; it takes exactly 1 cycle.
REQ-023 Right shifts truncate toward zero.
REQ-024 done is high for exactly the cycle after ACC; bits presented with valid in that cycle are accepted.
REQ-025 Latency is fixed: the last weight bit is sampled at edge N and the accumulator updates at edge N+2.
REQ-026 A lane contributes zero when its act exponent field is 0 (zero or subnormal), its weight is zero, or its weight is NaR.
REQ-027 An act exponent of 31 (Inf or NaN) sets nar for that lane and the lane contributes zero.
REQ-028 While prec_err is high, the FSM stays in SHIFT and discards bits, and no accumulation occurs.
REQ-029 Lanes are fully independent except for the shared FSM and counter.

Reset
REQ-030 On rst, all of the following clear immediately: state=IDLE, counter=0, accumulators=0, exp_out=0, done=0, busy=0, nar=0, prec_err=0.
REQ-031 Reset mid-word discards the partial word, and no done is issued.

Configuration
REQ-032 With FPMAC_SATURATE_EN defined, an accumulation overflow clamps to the signed maximum or minimum of ACC_WIDTH.
REQ-033 Without FPMAC_SATURATE_EN, the accumulator wraps modulo 2^ACC_WIDTH.

Structure
REQ-034 Package fp_posit_pkg holds: the FSM state enum, FP16 field widths, bias=15, and the LSB offset constant (25).
REQ-035 Sub-module posit_decode (combinational) converts PREC_MAX bits plus precision into sign, k, fraction, zero and NaR; it is instantiated once per lane.

Verification
REQ-036 LANES=4, exp_min=15, act=0x3C00 all lanes, posit4 0100 -> done pulse at edge N+2, each lane = 0x00000400.
REQ-037 Continuing: weights 1100, 0110, 0000, 1000 on lanes 0..3 -> lanes = 0x0, 0xC00, 0x400, 0x400, and nar=4'b1000.
REQ-038 ACC_WIDTH=16, act=0x7800, weight 0111, exp_min=15 -> lane=0x7FFF with FPMAC_SATURATE_EN; wrapped value without it.
REQ-039 set issued after 2 of 4 bits -> no done; the next 4 bits form a fresh word; clr=1 zeroes all lanes.
REQ-040 precision=2 -> prec_err=1, valid bits ignored, accumulators unchanged; rst asserted mid-ACC -> all outputs 0 immediately.
